// File: rtl/fu_wb_arbiter.sv
// Shared writeback: NB_SRC FU result FIFOs drained round-robin onto NB_WB registered ports.
// Latency: a source handshake in cycle n reaches wb_valid_o in cycle n+2 at the earliest.
// Backpressure: src_ready_o[s] is low while FIFO s is full; there is no same-cycle drain bypass.
module fu_wb_arbiter #(
   parameter  int NB_SRC = 4,
   parameter  int NB_WB  = 2,
   parameter  int DEPTH  = 2,
   parameter  int ID_W   = 6,
   parameter  int DATA_W = 64,
   localparam int SRC_W  = (NB_SRC > 1) ? $clog2(NB_SRC) : 1
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           flush_i,
   input  logic [NB_SRC-1:0]              src_valid_i,
   output logic [NB_SRC-1:0]              src_ready_o,
   input  logic [NB_SRC-1:0][ID_W-1:0]    src_id_i,
   input  logic [NB_SRC-1:0][DATA_W-1:0]  src_data_i,
   output logic [NB_WB-1:0]               wb_valid_o,
   output logic [NB_WB-1:0][ID_W-1:0]     wb_id_o,
   output logic [NB_WB-1:0][DATA_W-1:0]   wb_data_o,
   output logic [NB_WB-1:0][SRC_W-1:0]    wb_src_o,
   output logic                           busy_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int GW    = $clog2(NB_WB + 1);

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] data;
   } ent_t;

   ent_t                          mem_q    [NB_SRC][DEPTH];
   ent_t                          head     [NB_SRC];
   logic [PTR_W-1:0]              rd_ptr_q [NB_SRC];
   logic [PTR_W-1:0]              rd_ptr_d [NB_SRC];
   logic [PTR_W-1:0]              wr_ptr_q [NB_SRC];
   logic [PTR_W-1:0]              wr_ptr_d [NB_SRC];
   logic [CNT_W-1:0]              cnt_q    [NB_SRC];
   logic [CNT_W-1:0]              cnt_d    [NB_SRC];
   logic [NB_SRC-1:0]             push;
   logic [NB_SRC-1:0]             pop;
   logic [NB_SRC-1:0]             nonempty;
   logic [SRC_W-1:0]              rr_q;
   logic [SRC_W-1:0]              rr_d;
   logic [NB_WB-1:0]              gnt_vld;
   logic [NB_WB-1:0][SRC_W-1:0]   gnt_src;
   logic [SRC_W:0]                scan_sum;
   logic [SRC_W-1:0]              scan_idx;
   logic [GW-1:0]                 n_gnt;
   logic [NB_WB-1:0]              wb_valid_q;
   logic [NB_WB-1:0][ID_W-1:0]    wb_id_q;
   logic [NB_WB-1:0][DATA_W-1:0]  wb_data_q;
   logic [NB_WB-1:0][SRC_W-1:0]   wb_src_q;

   // Ready and emptiness decode from registered counts only; ready is held low during reset
   always_comb begin
      for (int s = 0; s < NB_SRC; s++) begin
         src_ready_o[s] = rstn && (cnt_q[s] < CNT_W'(DEPTH));
         nonempty[s]    = (cnt_q[s] != '0);
         head[s]        = mem_q[s][rd_ptr_q[s]];
      end
   end

   assign push = src_valid_i & src_ready_o;

   // Round-robin scan from rr_q: the k-th non-empty source found drives port k
   always_comb begin
      gnt_vld  = '0;
      gnt_src  = '0;
      pop      = '0;
      rr_d     = rr_q;
      n_gnt    = '0;
      scan_sum = '0;
      scan_idx = '0;
      for (int i = 0; i < NB_SRC; i++) begin
         scan_sum = {1'b0, rr_q} + (SRC_W+1)'(i);
         if (scan_sum >= (SRC_W+1)'(NB_SRC)) begin
            scan_sum = scan_sum - (SRC_W+1)'(NB_SRC);
         end
         scan_idx = scan_sum[SRC_W-1:0];
         if (nonempty[scan_idx] && (n_gnt < GW'(NB_WB))) begin
            for (int k = 0; k < NB_WB; k++) begin
               if (n_gnt == GW'(k)) begin
                  gnt_vld[k] = 1'b1;
                  gnt_src[k] = scan_idx;
               end
            end
            pop[scan_idx] = 1'b1;
            rr_d  = (scan_idx == SRC_W'(NB_SRC - 1)) ? '0 : scan_idx + SRC_W'(1);
            n_gnt = n_gnt + GW'(1);
         end
      end
   end

   // FIFO bookkeeping: flush clears everything, otherwise independent push and pop per source
   always_comb begin
      for (int s = 0; s < NB_SRC; s++) begin
         cnt_d[s]    = cnt_q[s];
         rd_ptr_d[s] = rd_ptr_q[s];
         wr_ptr_d[s] = wr_ptr_q[s];
         if (flush_i) begin
            cnt_d[s]    = '0;
            rd_ptr_d[s] = '0;
            wr_ptr_d[s] = '0;
         end else begin
            if (push[s]) begin
               wr_ptr_d[s] = (wr_ptr_q[s] == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q[s] + PTR_W'(1);
            end
            if (pop[s]) begin
               rd_ptr_d[s] = (rd_ptr_q[s] == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q[s] + PTR_W'(1);
            end
            if (push[s] && !pop[s]) begin
               cnt_d[s] = cnt_q[s] + CNT_W'(1);
            end else if (pop[s] && !push[s]) begin
               cnt_d[s] = cnt_q[s] - CNT_W'(1);
            end
         end
      end
   end

   // Entry storage needs no reset: only slots covered by a non-zero count are ever read
   always_ff @(posedge clk) begin
      for (int s = 0; s < NB_SRC; s++) begin
         if (push[s] && !flush_i) begin
            mem_q[s][wr_ptr_q[s]] <= {src_id_i[s], src_data_i[s]};
         end
      end
   end

   // FIFO pointer and count registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int s = 0; s < NB_SRC; s++) begin
            cnt_q[s]    <= '0;
            rd_ptr_q[s] <= '0;
            wr_ptr_q[s] <= '0;
         end
      end else begin
         for (int s = 0; s < NB_SRC; s++) begin
            cnt_q[s]    <= cnt_d[s];
            rd_ptr_q[s] <= rd_ptr_d[s];
            wr_ptr_q[s] <= wr_ptr_d[s];
         end
      end
   end

   // Writeback ports and scan pointer; ungranted ports keep their last id/data/src
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rr_q       <= '0;
         wb_valid_q <= '0;
         wb_id_q    <= '0;
         wb_data_q  <= '0;
         wb_src_q   <= '0;
      end else if (flush_i) begin
         wb_valid_q <= '0;
      end else begin
         rr_q       <= rr_d;
         wb_valid_q <= gnt_vld;
         for (int k = 0; k < NB_WB; k++) begin
            if (gnt_vld[k]) begin
               wb_id_q[k]   <= head[gnt_src[k]].id;
               wb_data_q[k] <= head[gnt_src[k]].data;
               wb_src_q[k]  <= gnt_src[k];
            end
         end
      end
   end

   assign wb_valid_o = wb_valid_q;
   assign wb_id_o    = wb_id_q;
   assign wb_data_o  = wb_data_q;
   assign wb_src_o   = wb_src_q;
   assign busy_o     = (|nonempty) | (|wb_valid_q);

endmodule

// File: doc/fu_wb_arbiter.md
# fu_wb_arbiter

Parametrised writeback arbiter between the functional units and the register-file writeback/completion ports. Each of `NB_SRC` FU result channels feeds a private `DEPTH`-entry FIFO. Every cycle a round-robin arbiter drains up to `NB_WB` FIFO heads onto `NB_WB` registered writeback ports. This replaces the fixed "one FU -> one WB port" wiring with shared, backpressured, multi-latency-tolerant writeback.

## Interface
Parameters:
- `NB_SRC`, 4, number of FU result channels (>= 1)
- `NB_WB`, 2, number of writeback ports (1 <= `NB_WB` <= `NB_SRC`)
- `DEPTH`, 2, entries per source FIFO (>= 1, any value, not only powers of two)
- `ID_W`, 6, instruction id width
- `DATA_W`, 64, result data width

Ports:
- `clk`  in  1  clock, all state on the rising edge
- `rstn`  in  1  asynchronous active-low reset
- `flush_i`  in  1  synchronous flush of all buffered results
- `src_valid_i`  in  `NB_SRC`  result valid, per source
- `src_ready_o`  out  `NB_SRC`  FIFO can accept, per source
- `src_id_i`  in  `NB_SRC`x`ID_W`  instruction id, per source
- `src_data_i`  in  `NB_SRC`x`DATA_W`  result data, per source
- `wb_valid_o`  out  `NB_WB`  writeback valid, per port
- `wb_id_o`  out  `NB_WB`x`ID_W`  id on port
- `wb_data_o`  out  `NB_WB`x`DATA_W`  data on port
- `wb_src_o`  out  `NB_WB`x`$clog2(NB_SRC)` (min 1)  source index that produced the port's result
- `busy_o`  out  1  any FIFO non-empty or any `wb_valid_o` set

## Operation
- Per-source FIFO:
  - Stores {id, data}. Count range is 0..`DEPTH`.
  - `src_ready_o[s]` = (count[s] < `DEPTH`), decoded from registered count only. There is no same-cycle drain bypass.
  - Enqueue when `src_valid_i[s] && src_ready_o[s]`.
  - Read/write pointers wrap at `DEPTH`.
- Arbitration (combinational on registered FIFO state):
  - The scan starts at `rr_q` and visits sources `rr_q`, `rr_q+1`, … mod `NB_SRC`.
  - The first `NB_WB` non-empty sources are granted, at most one entry per source per cycle.
  - The k-th grant in scan order drives port k. Ungranted ports produce `wb_valid_o[k]=0`, and their id/data/src outputs hold their previous value.
  - Each granted FIFO pops one entry.
- Pointer update: if at least one grant occurs, `rr_q` <= (last granted source + 1) mod `NB_SRC`. Otherwise `rr_q` holds.
- Writeback ports are registered. They load the granted head's id, data and source index every cycle.
- Per-source result order is preserved. No ordering guarantee exists across sources.
- Same-cycle push and pop on a non-full FIFO: both occur and count is unchanged.
- Push is impossible when full, even if the same cycle pops.
- Flush (`flush_i=1` at an edge) takes priority over push and pop:
  - all counts and pointers go to 0 and `wb_valid_o` goes to 0;
  - `rr_q` holds;
  - inputs presented that cycle are dropped, even though ready was 1.

## Timing
- Reset (while `rstn`=0, asynchronous):
  - all FIFOs empty, `rr_q`=0;
  - `wb_valid_o`=0, `wb_id_o`=0, `wb_data_o`=0, `wb_src_o`=0;
  - `busy_o`=0;
  - `src_ready_o` forced to 0 while `rstn`=0, and becomes all-1 in the first cycle after deassertion.
- Latency:
  - A handshake in cycle n produces `wb_valid_o` in cycle n+2 at the earliest.
  - One result per source per cycle is sustained.
  - Aggregate throughput is `NB_WB` results per cycle.
- Backpressure:
  - With `DEPTH`=1, a source that pushes every cycle sees ready=0 on the cycle after each push.
  - Full rate per source requires `DEPTH` >= 2.
- Fairness: a continuously non-empty source is granted within ceil(`NB_SRC`/`NB_WB`) cycles.
- Reset asserted mid-operation discards all buffered and in-flight results immediately.

## Test plan
- Reset and idle:
  - Stimulus: assert `rstn`=0 mid-traffic, then release.
  - Required: `wb_valid_o`=0, `busy_o`=0 and `src_ready_o`=0 during reset; `src_ready_o`=4'b1111 on the first cycle after release.
- Single source latency:
  - Stimulus: push id=5, data=0xDEAD on src 2 in cycle 0.
  - Required: `wb_valid_o`=2'b01, `wb_id_o[0]`=5, `wb_data_o[0]`=0xDEAD, `wb_src_o[0]`=2 in cycle 2, and nothing else.
- Round-robin:
  - Stimulus: all 4 sources push every cycle with `NB_WB`=2, starting from `rr_q`=0.
  - Required: grants are {0,1}, {2,3}, {0,1}… with port0 taking the lower-scan source.
  - Required: once FIFOs saturate, each `src_ready_o` toggles so that each source achieves 1 push per 2 cycles.
- Full FIFO:
  - Stimulus: with `DEPTH`=2, stall draining by keeping the other 3 sources saturated (`NB_WB`=1), and push src 0 three times back-to-back.
  - Required: ready=0 after the 2nd push, the third is held, and ids come out in push order.
- Flush:
  - Stimulus: fill 3 FIFOs, then assert `flush_i` together with a valid push on src 1.
  - Required: next cycle all counts are 0, `wb_valid_o`=0 and `busy_o`=0; the src 1 push never appears; `rr_q` is unchanged.
- Non-power-of-two wrap:
  - Stimulus: `NB_SRC`=3, `DEPTH`=3, random push/valid, 10k cycles.
  - Required: the scoreboard matches per-source order, there is no loss or duplication, and `rr_q` stays in 0..2.
